// File: rtl/text_console_sequencer.sv
// rtl/text_console_sequencer.sv - byte-stream to glyph-map write sequencer
//
// Turns a byte-wide character stream into writes on the font controller's
// glyph map (MAP_SIZE_X x MAP_SIZE_Y cells). It keeps a cursor, interprets
// LF/CR/BS/FF, and generates bulk blanking: one row on line advance, and the
// whole map on form feed and after reset.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   char_in/char_valid  incoming byte, accepted when char_ready is high
//   char_ready          high only in IDLE
//   write_glyph         registered map write strobe
//   addr, glyph_id      registered map address / glyph to write
//   cursor_col/row      current cursor position
//   busy                a row or full-map clear is in progress
module text_console_sequencer #(
  parameter int MAP_SIZE_X = 80,
  parameter int MAP_SIZE_Y = 60,
  parameter int ID_SIZE    = 7,
  parameter int ADDR_WIDTH = 13,
  parameter int BLANK_ID   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            char_in,
  input  logic                  char_valid,
  output logic                  char_ready,
  output logic                  write_glyph,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ID_SIZE-1:0]    glyph_id,
  output logic [6:0]            cursor_col,
  output logic [5:0]            cursor_row,
  output logic                  busy
);

  localparam logic [ID_SIZE-1:0]    BLANK    = ID_SIZE'(BLANK_ID);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(MAP_SIZE_X - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ALL = ADDR_WIDTH'(MAP_SIZE_X * MAP_SIZE_Y - 1);
  localparam logic [6:0]            MAX_COL  = 7'(MAP_SIZE_X - 1);
  localparam logic [5:0]            MAX_ROW  = 6'(MAP_SIZE_Y - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR_ROW = 2'd1,
    CLEAR_ALL = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_n;
  logic [6:0]              col_n;
  logic [5:0]              row_n;
  logic                    wg_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [ID_SIZE-1:0]      id_n;
  logic                    advance;

  logic [ADDR_WIDTH-1:0]   row_base;
  logic [ADDR_WIDTH-1:0]   cell_addr;
  logic                    printable;

  // Computed at full address width so row*80+col never truncates.
  assign row_base  = ADDR_WIDTH'(cursor_row) * ADDR_WIDTH'(MAP_SIZE_X);
  assign cell_addr = row_base + ADDR_WIDTH'(cursor_col);
  assign printable = (char_in >= 8'h20) && (char_in <= 8'h7E);

  assign char_ready = (state == IDLE);
  assign busy       = (state == CLEAR_ROW) || (state == CLEAR_ALL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLEAR_ALL;
      cnt         <= '0;
      cursor_col  <= '0;
      cursor_row  <= '0;
      write_glyph <= 1'b0;
      addr        <= '0;
      glyph_id    <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cursor_col  <= col_n;
      cursor_row  <= row_n;
      write_glyph <= wg_n;
      addr        <= addr_n;
      glyph_id    <= id_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    col_n   = cursor_col;
    row_n   = cursor_row;
    wg_n    = 1'b0;
    addr_n  = addr;
    id_n    = glyph_id;
    advance = 1'b0;

    case (state)
      IDLE: begin
        if (char_valid) begin
          if (printable) begin
            wg_n   = 1'b1;
            addr_n = cell_addr;
            id_n   = char_in[ID_SIZE-1:0];
            if (cursor_col == MAX_COL) begin
              col_n   = '0;
              advance = 1'b1;
            end else begin
              col_n = cursor_col + 7'd1;
            end
          end else begin
            case (char_in)
              8'h0A: begin
                col_n   = '0;
                advance = 1'b1;
              end
              8'h0D: col_n = '0;
              8'h08: begin
                // No reverse wrap: backspace at column 0 is a no-op.
                if (cursor_col != 7'd0) begin
                  col_n  = cursor_col - 7'd1;
                  wg_n   = 1'b1;
                  addr_n = cell_addr - ADDR_WIDTH'(1);
                  id_n   = BLANK;
                end
              end
              8'h0C: begin
                col_n   = '0;
                row_n   = '0;
                cnt_n   = '0;
                state_n = CLEAR_ALL;
              end
              default: ;
            endcase
          end

          // Row blanking targets the row the cursor has just moved onto;
          // row_base follows cursor_row, so it is already the new row then.
          if (advance) begin
            row_n   = (cursor_row == MAX_ROW) ? 6'd0 : cursor_row + 6'd1;
            cnt_n   = '0;
            state_n = CLEAR_ROW;
          end
        end
      end

      CLEAR_ROW: begin
        wg_n   = 1'b1;
        addr_n = row_base + cnt;
        id_n   = BLANK;
        if (cnt == LAST_COL) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + ADDR_WIDTH'(1);
        end
      end

      CLEAR_ALL: begin
        wg_n   = 1'b1;
        addr_n = cnt;
        id_n   = BLANK;
        if (cnt == LAST_ALL) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + ADDR_WIDTH'(1);
        end
      end

      default: begin
        state_n = CLEAR_ALL;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_text_console_sequencer.sv
// tb/tb_text_console_sequencer.sv - self-checking bench for text_console_sequencer
module tb_text_console_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        write_glyph;
  logic [12:0] addr;
  logic [6:0]  glyph_id;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;

  text_console_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .char_in     (char_in),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .write_glyph (write_glyph),
    .addr        (addr),
    .glyph_id    (glyph_id),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: cursor plus a queue of cell addresses still to be
  // blanked. While the queue is non-empty the block is busy and each edge
  // emits the next address; otherwise an accepted byte decides the output.
  int mcol, mrow;
  int pend[$];
  logic        exp_wg;
  int          exp_addr;
  int          exp_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_now();
    chk("char_ready", 32'(char_ready), 32'(pend.size() == 0));
    chk("busy", 32'(busy), 32'(pend.size() != 0));
    chk("write_glyph", 32'(write_glyph), 32'(exp_wg));
    if (exp_wg) begin
      chk("addr", 32'(addr), 32'(exp_addr));
      chk("glyph_id", 32'(glyph_id), 32'(exp_id));
    end
    chk("cursor_col", 32'(cursor_col), 32'(mcol));
    chk("cursor_row", 32'(cursor_row), 32'(mrow));
  endtask

  task automatic model_reset();
    mcol = 0; mrow = 0;
    exp_wg = 1'b0; exp_addr = 0; exp_id = 0;
    pend.delete();
    for (int a = 0; a < 4800; a++) pend.push_back(a);
  endtask

  task automatic line_advance();
    mrow = (mrow + 1) % 60;
    for (int c = 0; c < 80; c++) pend.push_back(mrow * 80 + c);
  endtask

  task automatic apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_wg = 1'b1; exp_addr = mrow * 80 + mcol; exp_id = int'(b) % 128;
      if (mcol < 79) mcol++;
      else begin mcol = 0; line_advance(); end
    end else if (b == 8'h0A) begin
      mcol = 0; line_advance();
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        exp_wg = 1'b1; exp_addr = mrow * 80 + mcol; exp_id = 0;
      end
    end else if (b == 8'h0C) begin
      mcol = 0; mrow = 0;
      for (int a = 0; a < 4800; a++) pend.push_back(a);
    end
  endtask

  // Called at a falling edge: check this cycle, drive inputs, advance one edge.
  task automatic tick(input logic v, input logic [7:0] b);
    logic acc;
    check_now();
    char_valid = v;
    char_in    = b;
    acc = v && (pend.size() == 0);
    @(posedge clk);
    exp_wg = 1'b0;
    if (pend.size() != 0) begin
      exp_wg = 1'b1; exp_addr = pend.pop_front(); exp_id = 0;
    end else if (acc) begin
      apply(b);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b1, b);
  endtask

  task automatic drain();
    while (pend.size() != 0) tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] b;
    r = $urandom_range(0, 99);
    if (r < 70)      b = 8'($urandom_range(32, 126));
    else if (r < 75) b = 8'h0A;
    else if (r < 82) b = 8'h08;
    else if (r < 86) b = 8'h0D;
    else begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h0C) b = 8'h00;
    end
    return b;
  endfunction

  initial begin
    rst = 1'b1;
    char_valid = 1'b0;
    char_in = 8'h00;
    model_reset();

    // Reset state, then the power-up full-map clear.
    repeat (2) @(negedge clk);
    check_now();
    chk("reset_addr", 32'(addr), 32'd0);
    chk("reset_glyph", 32'(glyph_id), 32'd0);
    rst = 1'b0;
    drain();

    // Back-to-back printables.
    send(8'h41);
    send(8'h42);
    tick(1'b0, 8'h00);
    chk("col_after_AB", 32'(cursor_col), 32'd2);

    // Move to row 2 col 5, then LF.
    send(8'h0A); drain();
    send(8'h0A); drain();
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    send(8'h0A);
    drain();
    chk("lf_row", 32'(cursor_row), 32'd3);

    // Move to row 59 col 79, then 'Z' wraps to 0/0 with row 0 blanked.
    for (int i = 0; i < 56; i++) begin send(8'h0A); drain(); end
    for (int i = 0; i < 79; i++) send(8'h30 + 8'(i % 10));
    send(8'h5A);
    drain();
    chk("wrap_row", 32'(cursor_row), 32'd0);
    chk("wrap_col", 32'(cursor_col), 32'd0);

    // Backspace behaviour and ignored codes.
    send(8'h31); send(8'h32); send(8'h33);
    send(8'h08); send(8'h08);
    send(8'h0D);
    send(8'h08);
    send(8'h7F); send(8'h09);
    send(8'h35);
    send(8'h0D);
    tick(1'b0, 8'h00);
    chk("bs_cr_col", 32'(cursor_col), 32'd0);

    // Randomized traffic; valid is also raised while busy (must be ignored).
    for (int i = 0; i < 600; i++) begin
      tick(1'($urandom_range(0, 3) != 0), rand_byte());
    end
    drain();

    // Form feed, then asynchronous reset in the middle of the full clear.
    send(8'h0C);
    while (!(exp_wg && exp_addr == 1000)) tick(1'b0, 8'h00);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_now();
    chk("midclr_addr", 32'(addr), 32'd0);
    chk("midclr_glyph", 32'(glyph_id), 32'd0);
    @(negedge clk);
    check_now();
    rst = 1'b0;
    drain();
    send(8'h48);
    tick(1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_console_sequencer.md
Name: text_console_sequencer

Overview:
- Sequences writes into the 80x60 glyph map of the font controller from a byte-wide character stream.
- Maintains a cursor and interprets control codes.
- Generates bulk blanking: one row on line advance, the full screen on form feed and after reset.
- Drives the font controller's write_glyph/addr/glyph_id inputs; one map write per clock maximum.

Parameters:
- MAP_SIZE_X, 80, columns in glyph map.
- MAP_SIZE_Y, 60, rows in glyph map.
- ID_SIZE, 7, glyph id width.
- ADDR_WIDTH, 13, map address width.
- BLANK_ID, 0, glyph id written when blanking.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- char_in  in  8  character byte.
- char_valid  in  1  char_in is valid.
- char_ready  out  1  block accepts char_in this cycle; equals (state==IDLE).
- write_glyph  out  1  map write strobe, registered.
- addr  out  ADDR_WIDTH  map address, registered.
- glyph_id  out  ID_SIZE  glyph to write, registered.
- cursor_col  out  7  current column, 0..MAP_SIZE_X-1.
- cursor_row  out  6  current row, 0..MAP_SIZE_Y-1.
- busy  out  1  state is CLEAR_ROW or CLEAR_ALL.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-high.
  - Reset values: write_glyph=0, addr=0, glyph_id=0, cursor 0/0, clear counter 0, state=CLEAR_ALL (char_ready=0, busy=1).
- States: IDLE, CLEAR_ROW, CLEAR_ALL.
- Handshake:
  - Accept occurs when char_valid && char_ready at a rising edge.
  - Every accepted byte is consumed, including ignored codes.
  - char_valid while char_ready=0 is not accepted; the producer holds the byte.
- Cell address: addr = row*MAP_SIZE_X + col, computed at ADDR_WIDTH with no truncation (max 4799).
- Accepted byte in cycle N; any direct write is visible as write_glyph=1 in cycle N+1. In IDLE with no accept, write_glyph=0.
- Printable 0x20..0x7E:
  - Write glyph_id=char_in[6:0] at the cursor.
  - If col<79: col+1.
  - If col==79: col=0, then line advance.
- Line advance:
  - row+1; row 59 wraps to 0.
  - Enter CLEAR_ROW for the new row.
- 0x0A (LF): col=0, line advance; no glyph write.
- 0x0D (CR): col=0; no write, state stays IDLE.
- 0x08 (BS):
  - If col>0: col-1, write BLANK_ID at the new position.
  - If col==0: no change and no write; no reverse wrap.
- 0x0C (FF): cursor 0/0, enter CLEAR_ALL.
- All other bytes (0x00..0x07, 0x09, 0x0B, 0x0E..0x1F, 0x7F..0xFF): consumed, no effect.
- CLEAR_ROW:
  - Counter c=0..79; each cycle registers write of BLANK_ID at row*80+c.
  - Writes are visible in cycles N+2..N+81; cycle N+1 carries the printable's write (wrap case) or write_glyph=0 (LF case).
  - Returns to IDLE at the edge issuing c=79.
  - char_ready is low for exactly 80 cycles (N+1..N+80).
- CLEAR_ALL:
  - Counter 0..4799 ascending; one BLANK_ID write per cycle.
  - Returns to IDLE at the edge issuing 4799; char_ready is low for 4800 cycles.
  - After reset release, addr 0 appears after the first edge, and char_ready rises after the 4800th edge.
- Cursor outputs update at the accept edge; they are stable during clears.
- Reset asserted mid-clear or mid-accept: immediate return to reset values, then a complete CLEAR_ALL restart; no partial state is retained.
- The block never issues reads; the font controller's read path is unaffected.

Test Plan:
- Reset release, char_valid=0 -> 4800 consecutive writes, addr 0..4799, glyph_id=0; char_ready rises after 4800th edge; cursor 0/0.
- After init, send 'A'(0x41), 'B'(0x42) back-to-back -> writes addr0 id 0x41, addr1 id 0x42 in consecutive cycles; cursor_col=2.
- At row 2 col 5, send 0x0A -> no write in N+1; writes addr 240..319 id 0 in N+2..N+81; char_ready low N+1..N+80; cursor row3 col0.
- Cursor row59 col79, send 'Z' -> write addr 4799 id 0x5A; then blank writes addr 0..79; cursor 0/0.
- Col 3 row 0, send 0x08 twice then 0x08 at col0 -> blanks at addr2, addr1; final BS produces no write; col=0. Bytes 0x0D, 0x7F, 0x09 -> no writes; 0x0D sets col=0.
- Send 0x0C, assert rst at clear count 1000 -> outputs reset asynchronously; after release a full 0..4799 sweep restarts and char_ready stays low throughout.
